// File: rtl/rsa_modexp_pkg.sv
`default_nettype none
// ============================================================================
// rsa_modexp_pkg
// Shared constants and the state encoding for the RSA modular exponentiator.
//   RSA_DATA_WIDTH : default operand/result width
//   STATE_W        : width of the exponentiator state register
//   state_e        : binary-encoded exponentiator states
// Revision: 1.0  initial release
// ============================================================================
package rsa_modexp_pkg;

  localparam int RSA_DATA_WIDTH = 32;
  localparam int STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_MUL  = 3'd2,
    ST_SQR  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rsa_modmul.sv
`default_nettype none
// ============================================================================
// rsa_modmul
// Interleaved MSB-first shift-add modular multiplier: product = a*b mod n.
// Takes exactly W clock edges per product: the first step is computed on the
// start edge straight from the inputs, so back-to-back products can be issued
// in the same cycle the previous done pulse is seen.
// Requires b < n and W >= 2; a may be any value.
//   clock, reset : clock, synchronous active-high reset
//   clr          : synchronous abort (clears all state)
//   start        : begin a product with a, b, n
//   a, b, n      : multiplier (scanned MSB first), multiplicand, modulus
//   done         : one-cycle pulse, product valid
//   product      : registered result, held until the next completion/clear
// Revision: 1.0  initial release
// ============================================================================
module rsa_modmul #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  acc_q, acc_d, mplr_q, mplr_d, mcand_q, mcand_d;
  logic [W-1:0]  mod_q, mod_d, prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;

  // Step operands: live inputs on the start edge, registered copies after.
  logic [W-1:0] s_acc, s_mcand, s_mod, dbl_r, acc_step;
  logic         s_bit;
  logic [W:0]   dbl, sum, ext_mod;

  always_comb begin
    s_acc   = start ? '0      : acc_q;
    s_bit   = start ? a[W-1]  : mplr_q[W-1];
    s_mcand = start ? b       : mcand_q;
    s_mod   = start ? n       : mod_q;
    ext_mod = {1'b0, s_mod};
    // acc < n, so 2*acc < 2n and one subtraction reduces it.
    dbl     = {s_acc, 1'b0};
    dbl_r   = (dbl >= ext_mod) ? (dbl[W-1:0] - s_mod) : dbl[W-1:0];
    // dbl_r < n and b < n, so one subtraction reduces the sum as well.
    sum      = {1'b0, dbl_r} + (s_bit ? {1'b0, s_mcand} : '0);
    acc_step = (sum >= ext_mod) ? (sum[W-1:0] - s_mod) : sum[W-1:0];
  end

  always_comb begin
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    mod_d   = mod_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start) begin
      acc_d   = acc_step;
      mplr_d  = {a[W-2:0], 1'b0};
      mcand_d = b;
      mod_d   = n;
      cnt_d   = CW'(1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d  = acc_step;
      mplr_d = {mplr_q[W-2:0], 1'b0};
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        prod_d = acc_step;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      mod_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      mod_q   <= mod_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign done    = done_q;
  assign product = prod_q;

endmodule
`default_nettype wire

// File: rtl/rsa_modexp.sv
`default_nettype none
// ============================================================================
// rsa_modexp
// Right-to-left binary modular exponentiation: rsa_dataout = M^E mod N.
// Sequences one rsa_modmul; each multiply/square is issued in the same cycle
// the previous product completes, so the key-bit decision costs no cycles.
//   clock, reset    : clock, synchronous active-high reset
//   rsa_rst         : synchronous clear from the CU, aborts and returns to IDLE
//   rsa_en          : level start request, sampled only in IDLE
//   rsa_datain      : M      rsa_modulusin : N      rsa_keyin : E
//   rsa_dataout     : registered result
//   rsa_ready       : result valid (held until rsa_rst/reset)
// Revision: 1.0  initial release
// ============================================================================
module rsa_modexp
  import rsa_modexp_pkg::*;
#(
  parameter int DATA_WIDTH = RSA_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rsa_rst,
  input  logic                  rsa_en,
  input  logic [DATA_WIDTH-1:0] rsa_datain,
  input  logic [DATA_WIDTH-1:0] rsa_modulusin,
  input  logic [DATA_WIDTH-1:0] rsa_keyin,
  output logic [DATA_WIDTH-1:0] rsa_dataout,
  output logic                  rsa_ready
);

  localparam int W = DATA_WIDTH;

  state_e       state_q, state_d;
  logic [W-1:0] m_q, m_d, n_q, n_d, e_q, e_d;
  logic [W-1:0] base_q, base_d, result_q, result_d, dout_q, dout_d;
  logic         first_q, first_d, ready_q, ready_d;

  logic         mm_start, mm_done;
  logic [W-1:0] mm_a, mm_b, mm_product;

  // Where to go once the current key bit (e[0]) is about to be processed.
  function automatic state_e next_bit_state(input logic [W-1:0] e);
    if (e[0])
      return ST_MUL;
    else if ((e >> 1) != '0)
      return ST_SQR;
    else
      return ST_DONE;
  endfunction

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    e_d      = e_q;
    base_d   = base_q;
    result_d = result_q;
    first_d  = 1'b0;
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rsa_en) begin
          m_d     = rsa_datain;
          n_d     = rsa_modulusin;
          e_d     = rsa_keyin;
          first_d = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (n_q < W'(2)) begin
          // Degenerate modulus: everything reduces to 0.
          result_d = '0;
          state_d  = ST_DONE;
        end else if (first_q) begin
          // base = (M * 1) mod N reduces an oversized message.
          mm_start = 1'b1;
          mm_a     = m_q;
          mm_b     = W'(1);
        end else if (mm_done) begin
          base_d   = mm_product;
          result_d = W'(1);
          state_d  = next_bit_state(e_q);
        end
      end
      ST_MUL: begin
        if (mm_done) begin
          result_d = mm_product;
          state_d  = ((e_q >> 1) != '0) ? ST_SQR : ST_DONE;
        end
      end
      ST_SQR: begin
        if (mm_done) begin
          base_d  = mm_product;
          e_d     = e_q >> 1;
          state_d = next_bit_state(e_q >> 1);
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Chain the next product onto the completing one, using the values
    // that are being written back this cycle.
    if (mm_done && (state_d == ST_MUL)) begin
      mm_start = 1'b1;
      mm_a     = result_d;
      mm_b     = base_d;
    end else if (mm_done && (state_d == ST_SQR)) begin
      mm_start = 1'b1;
      mm_a     = base_d;
      mm_b     = base_d;
    end

    ready_d = (state_q == ST_DONE);
    dout_d  = (state_q == ST_DONE) ? result_q : '0;
  end

  always_ff @(posedge clock) begin
    if (reset || rsa_rst) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      n_q      <= '0;
      e_q      <= '0;
      base_q   <= '0;
      result_q <= '0;
      dout_q   <= '0;
      first_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      e_q      <= e_d;
      base_q   <= base_d;
      result_q <= result_d;
      dout_q   <= dout_d;
      first_q  <= first_d;
      ready_q  <= ready_d;
    end
  end

  rsa_modmul #(
    .W (W)
  ) u_modmul (
    .clock   (clock),
    .reset   (reset),
    .clr     (rsa_rst),
    .start   (mm_start),
    .a       (mm_a),
    .b       (mm_b),
    .n       (n_q),
    .done    (mm_done),
    .product (mm_product)
  );

  assign rsa_dataout = dout_q;
  assign rsa_ready   = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp.sv
`default_nettype none
// ============================================================================
// tb_rsa_modexp
// Directed vectors for rsa_modexp with hand-computed results and latencies.
// Stimulus pushes the expected result into a queue; a monitor pops and
// compares on every rising edge of rsa_ready.
// Revision: 1.0  initial release
// ============================================================================
module tb_rsa_modexp;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, rsa_rst, rsa_en;
  logic [W-1:0] rsa_datain, rsa_modulusin, rsa_keyin, rsa_dataout;
  logic         rsa_ready;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           start;
  } exp_t;

  exp_t sb_q[$];

  rsa_modexp #(.DATA_WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .rsa_rst       (rsa_rst),
    .rsa_en        (rsa_en),
    .rsa_datain    (rsa_datain),
    .rsa_modulusin (rsa_modulusin),
    .rsa_keyin     (rsa_keyin),
    .rsa_dataout   (rsa_dataout),
    .rsa_ready     (rsa_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: every rising edge of rsa_ready must match the oldest expectation.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if ((rsa_ready === 1'b1) && !prev) begin
        if (sb_q.size() == 0) begin
          check("spurious_ready", 64'(rsa_ready), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", 64'(rsa_dataout), 64'(e.data));
          check("latency", 64'(cyc - e.start), 64'(e.lat));
        end
      end
      prev = (rsa_ready === 1'b1);
    end
  end

  // Clear with rsa_rst, start one operation, wait for ready (bounded).
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                        input logic [W-1:0] res, input int lat, input bit scramble);
    int waited;
    @(negedge clock);
    rsa_rst = 1'b1;
    rsa_en  = 1'b0;
    @(negedge clock);
    check("clear_ready", 64'(rsa_ready), 64'd0);
    check("clear_data", 64'(rsa_dataout), 64'd0);
    rsa_rst       = 1'b0;
    rsa_datain    = m;
    rsa_keyin     = e;
    rsa_modulusin = n;
    rsa_en        = 1'b1;
    sb_q.push_back('{data: res, lat: lat, start: cyc + 1});
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
      if (scramble && (rsa_ready !== 1'b1)) begin
        rsa_datain    = $urandom;
        rsa_keyin     = $urandom;
        rsa_modulusin = $urandom;
        rsa_en        = 1'($urandom_range(0, 1));
      end
    end while ((rsa_ready !== 1'b1) && (waited < 400));
    check("ready_within_bound", 64'(rsa_ready), 64'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    reset         = 1'b1;
    rsa_rst       = 1'b0;
    rsa_en        = 1'b1;
    rsa_datain    = 32'd5;
    rsa_keyin     = 32'd3;
    rsa_modulusin = 32'd33;
    repeat (3) @(negedge clock);
    check("reset_ready", 64'(rsa_ready), 64'd0);
    check("reset_data", 64'(rsa_dataout), 64'd0);
    reset  = 1'b0;
    rsa_en = 1'b0;

    // 5^3 mod 33 = 26, latency 32*(1+2+1)+2
    run_op(32'd5, 32'd3, 32'd33, 32'd26, 130, 1'b0);
    // rsa_en still high in DONE: no restart, output stable
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("hold_ready", 64'(rsa_ready), 64'd1);
      check("hold_data", 64'(rsa_dataout), 64'd26);
    end

    run_op(32'd26, 32'd7, 32'd33, 32'd5, 194, 1'b1);
    run_op(32'd5, 32'd3, 32'd33, 32'd26, 130, 1'b1);
    run_op(32'd9, 32'd0, 32'd33, 32'd1, 34, 1'b1);
    run_op(32'd123, 32'd77, 32'd1, 32'd0, 2, 1'b1);
    run_op(32'd7, 32'd3, 32'd0, 32'd0, 2, 1'b0);
    run_op(32'd40, 32'd3, 32'd33, 32'd13, 130, 1'b1);
    run_op(32'd0, 32'd5, 32'd33, 32'd0, 162, 1'b1);
    run_op(32'd2, 32'd10, 32'd1000, 32'd24, 194, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFB, 32'd4, 66, 1'b1);
    run_op(32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd1, 98, 1'b1);

    // Abort mid-operation
    @(negedge clock);
    rsa_rst = 1'b1;
    rsa_en  = 1'b0;
    @(negedge clock);
    rsa_rst       = 1'b0;
    rsa_datain    = 32'd5;
    rsa_keyin     = 32'd7;
    rsa_modulusin = 32'd33;
    rsa_en        = 1'b1;
    repeat (50) @(negedge clock);
    rsa_rst = 1'b1;
    @(negedge clock);
    check("abort_ready", 64'(rsa_ready), 64'd0);
    check("abort_data", 64'(rsa_dataout), 64'd0);
    rsa_rst = 1'b0;
    rsa_en  = 1'b0;
    repeat (250) @(negedge clock);
    check("abort_stays_idle", 64'(rsa_ready), 64'd0);

    // rsa_rst and rsa_en in the same cycle: stays idle
    rsa_rst = 1'b1;
    rsa_en  = 1'b1;
    @(negedge clock);
    check("rst_en_ready", 64'(rsa_ready), 64'd0);
    rsa_rst = 1'b0;
    rsa_en  = 1'b0;
    repeat (300) @(negedge clock);
    check("rst_en_stays_idle", 64'(rsa_ready), 64'd0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsa_modexp.md
RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width (W below); all widths and constants from constants.vh.
REQ-002 clock  input  1  system clock; all state changes on posedge clock.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clock.
REQ-004 rsa_rst  input  1  CU-side synchronous clear, active-high; aborts any operation and returns to IDLE.
REQ-005 rsa_en  input  1  level start request from CU; sampled only in IDLE.
REQ-006 rsa_datain  input  W  message/ciphertext operand M.
REQ-007 rsa_modulusin  input  W  modulus N.
REQ-008 rsa_keyin  input  W  exponent E (public or private key).
REQ-009 rsa_dataout  output  W  result M^E mod N, registered.
REQ-010 rsa_ready  output  1  high = result valid; low = idle or busy.

Function
REQ-011 States SHALL be IDLE, INIT, MUL, SQR, DONE, with one-hot or binary encoding per the shared state-width constant.
REQ-012 IDLE: rsa_ready=0; when rsa_en=1 and rsa_rst=0, latch M, N, E into internal registers, then go to INIT.
REQ-013 INIT: base = (1*M) mod N via modmul (reduces M>=N); result = 1; then go to the first key-bit decision.
REQ-014 Right-to-left binary exponentiation: scan the latched E from bit 0 upward; set bit -> MUL (result = result*base mod N); after MUL or a clear bit, if higher set bits remain -> SQR (base = base*base mod N), else -> DONE.
REQ-015 The bit decision SHALL be folded into state transitions and SHALL add no cycles.
REQ-016 Each modmul SHALL take exactly W cycles, MSB-first interleaved shift-add: acc = 2*acc mod N; if multiplier bit set, acc = acc + multiplicand mod N.
REQ-017 modmul internal datapath SHALL be W+1 bits, with a single conditional subtraction per step.
REQ-018 Latency from the rsa_en sampling edge to rsa_ready=1, for E!=0, SHALL be W*(1 + popcount(E) + floor(log2 E)) + 2 cycles.
REQ-019 For E=0 the latency SHALL be W+2 cycles.
REQ-020 DONE: rsa_dataout=result, rsa_ready=1.
REQ-021 DONE SHALL be held until rsa_rst or reset; rsa_en still high in DONE SHALL NOT restart.
REQ-022 A new operation SHALL require an rsa_rst pulse, which returns the block to IDLE.
REQ-023 rsa_en changes and operand input changes while busy SHALL be ignored; only latched values are used.
REQ-024 N<2 (0 or 1): skip exponentiation; rsa_dataout=0 and rsa_ready=1 two cycles after start.
REQ-025 E=0 with N>=2: result SHALL be 1.
REQ-026 M=0 with E!=0: result SHALL be 0.
REQ-027 M>=N SHALL be handled correctly through the INIT reduction.
REQ-028 rsa_rst=1 and rsa_en=1 in the same cycle: rsa_rst wins; the block stays in IDLE.
REQ-029 rsa_rst asserted mid-operation: next cycle state=IDLE, rsa_ready=0, rsa_dataout=0, and the modmul is aborted.

Reset
REQ-030 reset (or rsa_rst) SHALL force state=IDLE, rsa_ready=0, rsa_dataout=0, and clear all latched operands and modmul state.
REQ-031 reset SHALL take priority over every other input.

Structure
REQ-032 DATA_WIDTH, the state width, and the state encodings for this block SHALL live in constants.vh, alongside the existing CU constants.
REQ-033 One sub-module, rsa_modmul, SHALL implement the modular multiplier.
REQ-034 rsa_modmul ports: clock, reset, clr, start, a, b, n, done pulse, product.
REQ-035 rsa_modexp SHALL sequence rsa_modmul and hold no arithmetic of its own beyond muxing.

Verification
REQ-036 W=32, M=5, E=3, N=33 -> rsa_dataout=26; rsa_ready rises exactly 130 cycles after the start edge.
REQ-037 M=26, E=7, N=33 -> rsa_dataout=5, latency 194 cycles; then rsa_rst, rerun with E=3 -> 26.
REQ-038 E=0, N=33, M=9 -> output 1 after 34 cycles; N=1, any M/E -> output 0 after 2 cycles.
REQ-039 M=40 (>N), E=3, N=33 -> 7^3 mod 33 = 13.
REQ-040 Start M=5, E=7, N=33, assert rsa_rst at cycle 50 -> IDLE, ready=0, dataout=0 next cycle.
REQ-041 Hold rsa_en=1 through DONE for 20 cycles -> no restart and output stable.
REQ-042 Same-cycle rsa_rst+rsa_en -> remains in IDLE.
